// File: rtl/lpm_pkg.sv
// Shared types for the multi-channel laser pulse monitor.
// Channel FSM encoding and fail-bit positions.
package lpm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_FAULT = 2'd3
  } ch_state_e;

  localparam int FB_PW_LO = 0;
  localparam int FB_PW_HI = 1;
  localparam int FB_RATE  = 2;
  localparam int NUM_FB   = 3;

endpackage

// File: rtl/lpm_channel.sv
// One laser channel: input sync, tick sampling, edge detect,
// width/period counters, sticky faults and the width window.
//   clk, rst       : clock, async active-high reset
//   tick_i         : one-clk sample enable from the prescaler
//   en_i           : channel enable; low forces IDLE, clears faults
//   clear_fail_i   : level request to leave FAULT (input must be low)
//   pulse_i        : raw pulse already gated by laser_ready (async)
//   pw_*_i, per_*_i: width / period limits in ticks
//   fail_o         : sticky fail bits, indexed by FB_* positions
//   win_o          : width inside legal window while high
module lpm_channel
  import lpm_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_i,
  input  logic              en_i,
  input  logic              clear_fail_i,
  input  logic              pulse_i,
  input  logic [CNT_W-1:0]  pw_min_i,
  input  logic [CNT_W-1:0]  pw_max_i,
  input  logic [CNT_W-1:0]  per_min_i,
  input  logic [CNT_W-1:0]  per_max_i,
  output logic [NUM_FB-1:0] fail_o,
  output logic              win_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic s1_q, s2_q, smp_q, prv_q;
  logic rise, fall;

  ch_state_e         state_q, state_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic [NUM_FB-1:0] fail_q, fail_d;
  logic              win_q, win_d;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Two-flop synchroniser every clk, then a
  // sample/previous pair that only moves on tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      smp_q <= 1'b0;
      prv_q <= 1'b0;
    end else begin
      s1_q <= pulse_i;
      s2_q <= s1_q;
      if (tick_i) begin
        smp_q <= s2_q;
        prv_q <= smp_q;
      end
    end
  end

  assign rise = smp_q & ~prv_q;
  assign fall = ~smp_q & prv_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      pcnt_q  <= '0;
      fail_q  <= '0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      pcnt_q  <= pcnt_d;
      fail_q  <= fail_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    pcnt_d  = pcnt_q;
    fail_d  = fail_q;
    win_d   = win_q;
    if (tick_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d = ST_HIGH;
            wcnt_d  = CNT_ONE;
            pcnt_d  = CNT_ONE;
          end
        end
        ST_HIGH: begin
          wcnt_d = sat_inc(wcnt_q);
          pcnt_d = sat_inc(pcnt_q);
          if (fall) begin
            if (wcnt_q < pw_min_i) begin
              fail_d[FB_PW_LO] = 1'b1;
              state_d = ST_FAULT;
            end else begin
              state_d = ST_LOW;
            end
          end else if (wcnt_q == pw_max_i) begin
            // pw_max samples already high and still high:
            // the pulse is now at least pw_max+1 wide.
            fail_d[FB_PW_HI] = 1'b1;
            state_d = ST_FAULT;
          end
        end
        ST_LOW: begin
          pcnt_d = sat_inc(pcnt_q);
          if (rise) begin
            if (pcnt_q < per_min_i) begin
              fail_d[FB_RATE] = 1'b1;
              state_d = ST_FAULT;
            end else begin
              state_d = ST_HIGH;
              wcnt_d  = CNT_ONE;
              pcnt_d  = CNT_ONE;
            end
          end else if (pcnt_q > per_max_i) begin
            state_d = ST_IDLE;
          end
        end
        ST_FAULT: begin
          // Clear only honoured with the pulse low;
          // a rejected request is simply dropped.
          if (clear_fail_i && !smp_q) begin
            fail_d  = '0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (state_d == ST_IDLE || state_d == ST_FAULT) begin
        wcnt_d = '0;
        pcnt_d = '0;
      end
      if (!en_i) begin
        state_d = ST_IDLE;
        fail_d  = '0;
        wcnt_d  = '0;
        pcnt_d  = '0;
      end
      win_d = (state_d == ST_HIGH)
           && (wcnt_d >= pw_min_i)
           && (wcnt_d <= pw_max_i);
    end
  end

  assign fail_o = fail_q;
  assign win_o  = win_q;

endmodule

// File: rtl/laser_pulse_monitor_mc.sv
// Multi-channel laser pulse monitor feeding the safety interlock.
// Ports: clk, rst (async high), clear_fail, ch_enable,
//   laser_pulse_in, laser_ready, pw_min/pw_max/per_min/per_max
//   (channel i at [i*CNT_W +: CNT_W]); outputs sticky
//   fail_pw_lo/fail_pw_hi/fail_rate, width_window,
//   fail_any and laser_permit (registered, every clk).
module laser_pulse_monitor_mc
  import lpm_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 24,
  parameter int DIV_LOG2 = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_fail,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic [NUM_CH-1:0]       laser_pulse_in,
  input  logic [NUM_CH-1:0]       laser_ready,
  input  logic [NUM_CH*CNT_W-1:0] pw_min,
  input  logic [NUM_CH*CNT_W-1:0] pw_max,
  input  logic [NUM_CH*CNT_W-1:0] per_min,
  input  logic [NUM_CH*CNT_W-1:0] per_max,
  output logic [NUM_CH-1:0]       fail_pw_lo,
  output logic [NUM_CH-1:0]       fail_pw_hi,
  output logic [NUM_CH-1:0]       fail_rate,
  output logic [NUM_CH-1:0]       width_window,
  output logic                    fail_any,
  output logic                    laser_permit
);

  logic tick;
  logic fail_any_q, fail_any_d;
  logic permit_q;

  if (DIV_LOG2 == 0) begin : g_nodiv
    assign tick = 1'b1;
  end else begin : g_div
    logic [DIV_LOG2-1:0] div_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) div_q <= '0;
      else     div_q <= div_q + 1'b1;
    end
    assign tick = (div_q == '0);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [NUM_FB-1:0] fail;
    lpm_channel #(.CNT_W(CNT_W)) u_ch (
      .clk          (clk),
      .rst          (rst),
      .tick_i       (tick),
      .en_i         (ch_enable[i]),
      .clear_fail_i (clear_fail),
      .pulse_i      (laser_pulse_in[i] & laser_ready[i]),
      .pw_min_i     (pw_min[i*CNT_W +: CNT_W]),
      .pw_max_i     (pw_max[i*CNT_W +: CNT_W]),
      .per_min_i    (per_min[i*CNT_W +: CNT_W]),
      .per_max_i    (per_max[i*CNT_W +: CNT_W]),
      .fail_o       (fail),
      .win_o        (width_window[i])
    );
    assign fail_pw_lo[i] = fail[FB_PW_LO];
    assign fail_pw_hi[i] = fail[FB_PW_HI];
    assign fail_rate[i]  = fail[FB_RATE];
  end

  // Disabled channels are masked at once, even if their
  // bits only clear on the next tick.
  assign fail_any_d =
    |((fail_pw_lo | fail_pw_hi | fail_rate) & ch_enable);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_any_q <= 1'b0;
      permit_q   <= 1'b0;
    end else begin
      fail_any_q <= fail_any_d;
      permit_q   <= ~fail_any_d;
    end
  end

  assign fail_any     = fail_any_q;
  assign laser_permit = permit_q;

endmodule
